// File: rtl/chip_vector_tester_if.sv
// Bus bundle for the vector tester: host control/status, table load port
// and the chip-under-test pin connections.
interface chip_vector_tester_if #(
    parameter int N_IN  = 1,
    parameter int N_OUT = 1,
    parameter int DEPTH = 16
) ();
    localparam int AW = $clog2(DEPTH);

    logic             start;
    logic [AW:0]      num_vec;
    logic             load_en;
    logic [AW-1:0]    load_addr;
    logic [N_IN-1:0]  load_stim;
    logic [N_OUT-1:0] load_exp;
    logic [N_OUT-1:0] load_mask;
    logic [N_IN-1:0]  dut_in;
    logic [N_OUT-1:0] dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [15:0]      err_count;
    logic [N_OUT-1:0] fail_flags;
    logic [AW-1:0]    first_fail_idx;

    // Environment side: host plus the chip that answers on dut_out
    modport master (
        output start, num_vec, load_en, load_addr, load_stim, load_exp, load_mask, dut_out,
        input  dut_in, busy, done, pass, err_count, fail_flags, first_fail_idx
    );

    // Tester side
    modport slave (
        input  start, num_vec, load_en, load_addr, load_stim, load_exp, load_mask, dut_out,
        output dut_in, busy, done, pass, err_count, fail_flags, first_fail_idx
    );
endinterface

// File: rtl/chip_vector_tester.sv
// Vector tester for the D2 chip: applies stimulus from a loadable table,
// waits SETTLE cycles, compares the synchronized chip outputs against
// masked expected values, waits HOLD cycles, and moves to the next entry.
// SETTLE must be at least 3 and HOLD at least 1.
module chip_vector_tester #(
    parameter int N_IN   = 1,
    parameter int N_OUT  = 1,
    parameter int DEPTH  = 16,
    parameter int SETTLE = 50,
    parameter int HOLD   = 50
) (
    input logic                 clk,
    input logic                 reset,
    chip_vector_tester_if.slave bus
);
    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_MAX = (SETTLE > HOLD) ? SETTLE : HOLD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_HOLD,
        S_DONE
    } state_t;

    state_t           state;
    logic [AW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic [AW:0]      vec_count;

    logic [N_IN-1:0]  dut_in_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic [15:0]      err_count_r;
    logic [N_OUT-1:0] fail_flags_r;
    logic [AW-1:0]    first_fail_r;

    logic [N_IN-1:0]  stim_mem [DEPTH];
    logic [N_OUT-1:0] exp_mem  [DEPTH];
    logic [N_OUT-1:0] mask_mem [DEPTH];

    logic [N_OUT-1:0] sync_1;
    logic [N_OUT-1:0] sync_2;

    logic [AW:0]      num_clamped;
    logic [N_OUT-1:0] diff;
    logic             last_vec;
    logic [15:0]      err_next;

    assign bus.dut_in         = dut_in_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.pass           = pass_r;
    assign bus.err_count      = err_count_r;
    assign bus.fail_flags     = fail_flags_r;
    assign bus.first_fail_idx = first_fail_r;

    // Table writes are accepted only while no run is in progress; contents survive reset
    always_ff @(posedge clk) begin
        if (bus.load_en && !busy_r) begin
            stim_mem[bus.load_addr] <= bus.load_stim;
            exp_mem[bus.load_addr]  <= bus.load_exp;
            mask_mem[bus.load_addr] <= bus.load_mask;
        end
    end

    // Two-flop synchronizer for the asynchronous chip outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= bus.dut_out;
            sync_2 <= sync_1;
        end
    end

    // Requested vector count clamped to the table size, masked compare, saturating error increment
    always_comb begin
        num_clamped = bus.num_vec;
        if (bus.num_vec > (AW+1)'(DEPTH)) begin
            num_clamped = (AW+1)'(DEPTH);
        end
        diff     = (sync_2 ^ exp_mem[idx]) & mask_mem[idx];
        last_vec = ({1'b0, idx} == (vec_count - 1'b1));
        err_next = (err_count_r == 16'hFFFF) ? err_count_r : (err_count_r + 16'd1);
    end

    // Sequencer: apply, settle, check, hold per vector; all outputs registered here
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            idx          <= '0;
            cnt          <= '0;
            vec_count    <= '0;
            dut_in_r     <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            err_count_r  <= '0;
            fail_flags_r <= '0;
            first_fail_r <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        err_count_r  <= '0;
                        fail_flags_r <= '0;
                        first_fail_r <= '0;
                        done_r       <= 1'b0;
                        pass_r       <= 1'b0;
                        idx          <= '0;
                        cnt          <= '0;
                        vec_count    <= num_clamped;
                        if (num_clamped == '0) begin
                            state <= S_DONE;
                        end else begin
                            state  <= S_APPLY;
                            busy_r <= 1'b1;
                        end
                    end else if (state == S_DONE) begin
                        done_r <= 1'b1;
                        pass_r <= (err_count_r == '0);
                    end
                end

                S_APPLY: begin
                    dut_in_r <= stim_mem[idx];
                    cnt      <= '0;
                    state    <= S_SETTLE;
                end

                S_SETTLE: begin
                    if (cnt == CW'(SETTLE - 1)) begin
                        cnt   <= '0;
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_CHECK: begin
                    if (diff != '0) begin
                        err_count_r  <= err_next;
                        fail_flags_r <= fail_flags_r | diff;
                        if (err_count_r == '0) begin
                            first_fail_r <= idx;
                        end
                    end
                    cnt   <= '0;
                    state <= S_HOLD;
                end

                S_HOLD: begin
                    if (cnt == CW'(HOLD - 1)) begin
                        cnt <= '0;
                        if (last_vec) begin
                            state  <= S_DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            pass_r <= (err_count_r == '0);
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_APPLY;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_chip_vector_tester.sv
// Bench for chip_vector_tester: a chip model (inverter or faulty buffer) closes
// the loop, a reference model predicts each run's results, and a monitor checks
// them when DONE rises.
module tb_chip_vector_tester;
    localparam int N_IN   = 1;
    localparam int N_OUT  = 1;
    localparam int DEPTH  = 16;
    localparam int SETTLE = 50;
    localparam int HOLD   = 50;
    localparam int AW     = $clog2(DEPTH);
    localparam int PERIOD = SETTLE + HOLD + 2;

    typedef struct {
        int               latency;
        int               start_cyc;
        int               errs;
        logic [N_OUT-1:0] flags;
        logic [AW-1:0]    first;
        logic             pass;
        logic             active;
        logic [N_IN-1:0]  pins;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic faulty;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [N_IN-1:0]  m_stim [DEPTH];
    logic [N_OUT-1:0] m_exp  [DEPTH];
    logic [N_OUT-1:0] m_mask [DEPTH];
    logic [N_IN-1:0]  model_pins;
    exp_t             sb_q [$];

    chip_vector_tester_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH)) bus ();

    chip_vector_tester #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH), .SETTLE(SETTLE), .HOLD(HOLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Chip under test: a good part inverts, a faulty one passes straight through
    assign bus.dut_out = faulty ? N_OUT'(bus.dut_in) : N_OUT'(~bus.dut_in);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected outcome of a run from the table and the chip's transfer function
    function automatic exp_t model_run(input int nreq);
        exp_t             r;
        int               n;
        logic [N_OUT-1:0] resp;
        logic [N_OUT-1:0] d;
        n = (nreq > DEPTH) ? DEPTH : nreq;
        r.errs      = 0;
        r.flags     = '0;
        r.first     = '0;
        r.start_cyc = 0;
        for (int i = 0; i < n; i++) begin
            resp = faulty ? N_OUT'(m_stim[i]) : N_OUT'(~m_stim[i]);
            d    = (resp ^ m_exp[i]) & m_mask[i];
            if (d != '0) begin
                if (r.errs == 0) r.first = AW'(i);
                r.errs++;
                r.flags = r.flags | d;
            end
        end
        r.pass    = (r.errs == 0);
        r.active  = (n > 0);
        r.pins    = (n == 0) ? model_pins : m_stim[n-1];
        r.latency = (n == 0) ? 1 : n * PERIOD;
        return r;
    endfunction

    task automatic load_entry(input int addr, input logic [N_IN-1:0] s,
                              input logic [N_OUT-1:0] e, input logic [N_OUT-1:0] m);
        bus.load_en   = 1'b1;
        bus.load_addr = AW'(addr);
        bus.load_stim = s;
        bus.load_exp  = e;
        bus.load_mask = m;
        m_stim[addr]  = s;
        m_exp[addr]   = e;
        m_mask[addr]  = m;
        @(negedge clk);
        bus.load_en = 1'b0;
    endtask

    // Starts a run, optionally hammers the load port while busy, and waits for the monitor
    task automatic apply_stimulus(input int nreq, input int disturb);
        exp_t e;
        int   budget;
        logic busy_seen;
        e = model_run(nreq);
        e.start_cyc = cyc + 1;
        model_pins  = e.pins;
        sb_q.push_back(e);
        budget      = e.latency + 20;
        busy_seen   = 1'b0;
        bus.num_vec = (AW+1)'(nreq);
        bus.start   = 1'b1;
        for (int k = 0; k < budget && sb_q.size() != 0; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy) busy_seen = 1'b1;
            if (disturb != 0 && bus.busy) begin
                bus.load_en = 1'b1;
                if (disturb == 1) begin
                    bus.load_addr = AW'(1);
                    bus.load_stim = '1;
                    bus.load_exp  = '1;
                    bus.load_mask = '1;
                end else begin
                    bus.load_addr = AW'($urandom_range(DEPTH - 1, 0));
                    bus.load_stim = N_IN'($urandom);
                    bus.load_exp  = N_OUT'($urandom);
                    bus.load_mask = N_OUT'($urandom);
                end
            end else begin
                bus.load_en = 1'b0;
            end
        end
        bus.load_en = 1'b0;
        bus.start   = 1'b0;
        check_output("run_completed_pending", sb_q.size(), 0);
        check_output("busy_seen", busy_seen, e.active);
        sb_q.delete();
        @(negedge clk);
    endtask

    // Monitor: on each rising DONE, pop the prediction and compare results
    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                done_prev = 1'b0;
            end else begin
                if (bus.done && !done_prev) begin
                    if (sb_q.size() == 0) begin
                        check_output("unexpected_done_pending", sb_q.size(), 1);
                    end else begin
                        e = sb_q.pop_front();
                        check_output("latency", cyc - e.start_cyc, e.latency);
                        check_output("err_count", bus.err_count, e.errs);
                        check_output("fail_flags", bus.fail_flags, e.flags);
                        check_output("first_fail_idx", bus.first_fail_idx, e.first);
                        check_output("pass", bus.pass, e.pass);
                        check_output("dut_in_final", bus.dut_in, e.pins);
                        check_output("busy_at_done", bus.busy, 0);
                    end
                end
                done_prev = bus.done;
            end
        end
    end

    // Stimulus: directed cases first, then randomized tables and run lengths
    initial begin
        reset         = 1'b1;
        faulty        = 1'b0;
        model_pins    = '0;
        bus.start     = 1'b0;
        bus.num_vec   = '0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_stim = '0;
        bus.load_exp  = '0;
        bus.load_mask = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_output("reset_busy", bus.busy, 0);
        check_output("reset_done", bus.done, 0);
        check_output("reset_pass", bus.pass, 0);
        check_output("reset_err_count", bus.err_count, 0);
        check_output("reset_fail_flags", bus.fail_flags, 0);
        check_output("reset_first_fail_idx", bus.first_fail_idx, 0);
        check_output("reset_dut_in", bus.dut_in, 0);

        load_entry(0, 1'b0, 1'b1, 1'b1);
        load_entry(1, 1'b1, 1'b0, 1'b1);
        apply_stimulus(2, 0);

        faulty = 1'b1;
        apply_stimulus(2, 0);

        load_entry(0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(2, 0);

        load_entry(0, 1'b0, 1'b1, 1'b1);
        faulty = 1'b0;
        apply_stimulus(0, 0);

        apply_stimulus(2, 1);

        // Abort during SETTLE of vector 1 with an error already counted
        faulty      = 1'b1;
        bus.num_vec = (AW+1)'(2);
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (PERIOD + 20) @(negedge clk);
        check_output("pre_abort_err_count", bus.err_count, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("abort_busy", bus.busy, 0);
        check_output("abort_done", bus.done, 0);
        check_output("abort_dut_in", bus.dut_in, 0);
        check_output("abort_err_count", bus.err_count, 0);
        check_output("abort_fail_flags", bus.fail_flags, 0);
        model_pins = '0;
        faulty     = 1'b0;
        @(negedge clk);
        apply_stimulus(2, 0);

        for (int run = 0; run < 10; run++) begin
            for (int a = 0; a < DEPTH; a++) begin
                load_entry(a, N_IN'($urandom), N_OUT'($urandom), N_OUT'($urandom));
            end
            faulty = 1'($urandom);
            apply_stimulus((run == 3) ? 20 : int'($urandom_range(DEPTH, 0)), int'($urandom_range(2, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the bench never hangs
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
